spike_rate_decoder: RTL

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/spike_rate_decoder_pkg.sv | 12 +
 rtl/spike_rate_decoder_sat_counter.sv | 49 ++++
 rtl/spike_rate_decoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/spike_rate_decoder_pkg.sv
// Shared definitions for the spike rate decoder: default counter width and
// the two-state controller encoding used by the top level.
package spike_pkg;

    // Default width of the window length, spike count and interval fields.
    localparam int CNT_W_DEF = 8;

    // Controller states. IDLE holds results; RUN samples the spike train.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/spike_rate_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear.
// The counter exposes its would-be next value (count plus the current
// increment, clamped at all-ones) so the owner can capture a result that
// already includes the sample of the current cycle, on the same edge that
// clears the counter for the next measurement.
module sat_counter
    import spike_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count_nxt,
    output logic         sat_nxt
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Saturating increment: stick at all-ones instead of wrapping.
    always_comb begin
        count_nxt = count_r;
        if (inc && (count_r != CNT_MAX)) begin
            count_nxt = count_r + CNT_ONE;
        end else begin
            count_nxt = count_r;
        end
    end

    // A value of all-ones means the true count may have been larger.
    assign sat_nxt = (count_nxt == CNT_MAX);

    // Counter register; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_nxt;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder.
// While enabled, counts spikes over back-to-back windows of win_len cycles
// (0 selects the full 2^CNT_W range) and measures the interval between
// consecutive spikes. Both results are registered and announced with
// one-cycle valid pulses. Dropping ena discards any partial window and
// forgets the previous spike, so the first spike after re-enabling gives
// no interval.
module spike_rate_decoder
    import spike_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike,
    input  logic [CNT_W-1:0] win_len,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic             rate_sat,
    output logic [CNT_W-1:0] isi,
    output logic             isi_valid,
    output logic             isi_sat
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Controller and window bookkeeping.
    logic [0:0]       state_r;
    logic [CNT_W-1:0] len_r;        // length of the window in progress
    logic [CNT_W-1:0] pos_r;        // current cycle index inside the window
    logic             have_prev_r;  // a spike has been seen since entering RUN

    // Per-cycle decode.
    logic             run_s;        // this cycle is a sampled RUN cycle
    logic             last_s;       // this cycle is the final one of the window

    // Window spike counter.
    logic             win_clr_s;
    logic             win_inc_s;
    logic [CNT_W-1:0] win_nxt_s;
    logic             win_sat_s;

    // Inter-spike interval counter.
    logic             isi_clr_s;
    logic             isi_inc_s;
    logic [CNT_W-1:0] isi_nxt_s;
    logic             isi_sat_s;

    // Output registers.
    logic [CNT_W-1:0] rate_r;
    logic             rate_valid_r;
    logic             rate_sat_r;
    logic [CNT_W-1:0] isi_r;
    logic             isi_valid_r;
    logic             isi_sat_r;

    // Cycle decode and counter controls.
    // A cycle is sampled only when already in RUN and ena is still high; the
    // cycle whose edge drops back to IDLE contributes nothing. len_r of zero
    // wraps to all-ones here, which is exactly the last index of a full-range
    // window.
    always_comb begin
        run_s     = (state_r == ST_RUN) && ena;
        last_s    = run_s && (pos_r == (len_r - CNT_ONE));
        // Window count restarts at each window boundary and whenever idle.
        win_inc_s = run_s && spike;
        win_clr_s = (!run_s) || last_s;
        // Interval counter holds "cycles since last spike minus one", so its
        // incremented value is the interval ending at a spike this cycle.
        isi_inc_s = run_s;
        isi_clr_s = (!run_s) || spike;
    end

    // Spike count within the current window.
    sat_counter #(
        .W         (CNT_W)
    ) u_win_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (win_clr_s),
        .inc       (win_inc_s),
        .count_nxt (win_nxt_s),
        .sat_nxt   (win_sat_s)
    );

    // Cycles elapsed since the previous spike.
    sat_counter #(
        .W         (CNT_W)
    ) u_isi_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (isi_clr_s),
        .inc       (isi_inc_s),
        .count_nxt (isi_nxt_s),
        .sat_nxt   (isi_sat_s)
    );

    // IDLE/RUN controller following ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ena) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!ena) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Window position and length capture.
    // Outside sampled cycles win_len is tracked so the value present on the
    // entry edge becomes the first window's length; afterwards it is only
    // re-captured on the edge that closes a window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r <= CNT_ZERO;
            len_r <= CNT_ZERO;
        end else if (!run_s) begin
            pos_r <= CNT_ZERO;
            len_r <= win_len;
        end else if (last_s) begin
            pos_r <= CNT_ZERO;
            len_r <= win_len;
        end else begin
            pos_r <= pos_r + CNT_ONE;
            len_r <= len_r;
        end
    end

    // Remember whether a reference spike exists for interval measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_prev_r <= 1'b0;
        end else if (!run_s) begin
            have_prev_r <= 1'b0;
        end else begin
            have_prev_r <= have_prev_r | spike;
        end
    end

    // Rate result: captured on the window's closing edge, including that
    // cycle's spike.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_r       <= CNT_ZERO;
            rate_sat_r   <= 1'b0;
            rate_valid_r <= 1'b0;
        end else if (last_s) begin
            rate_r       <= win_nxt_s;
            rate_sat_r   <= win_sat_s;
            rate_valid_r <= 1'b1;
        end else begin
            rate_r       <= rate_r;
            rate_sat_r   <= rate_sat_r;
            rate_valid_r <= 1'b0;
        end
    end

    // Interval result: captured on every spike that has a predecessor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi_r       <= CNT_ZERO;
            isi_sat_r   <= 1'b0;
            isi_valid_r <= 1'b0;
        end else if (run_s && spike && have_prev_r) begin
            isi_r       <= isi_nxt_s;
            isi_sat_r   <= isi_sat_s;
            isi_valid_r <= 1'b1;
        end else begin
            isi_r       <= isi_r;
            isi_sat_r   <= isi_sat_r;
            isi_valid_r <= 1'b0;
        end
    end

    assign rate       = rate_r;
    assign rate_valid = rate_valid_r;
    assign rate_sat   = rate_sat_r;
    assign isi        = isi_r;
    assign isi_valid  = isi_valid_r;
    assign isi_sat    = isi_sat_r;

endmodule
